// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and helpers for the instruction-fetch controller.
package fetch_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
  localparam int unsigned INSTR_BYTES = 4;
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;
  function automatic logic pc_bad(input word_t pc, input word_t last_pc);
    return (pc[1:0] != 2'b00) || (pc > last_pc);
  endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO of {pc, instr} with push, pop, flush and occupancy count.
module fetch_skid_buf
  import fetch_ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d, do_push, do_pop;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d   = mem_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && !flush_i;
    if (do_push) mem_d[wr_q] = din_i;
    rd_d  = flush_i ? 1'b0 : rd_q ^ do_pop;
    wr_d  = flush_i ? 1'b0 : wr_q ^ do_push;
    cnt_d = flush_i ? 2'd0 : cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, skid-buffered delivery, redirects and fault halt.
// Optional FETCH_CTRL_PERF_EN adds transfer/stall/flush performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter word_t       RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 4096
) (
  input  logic  clk_i,
  input  logic  rst_i,
  output word_t imem_pc_o,
  output logic  imem_req_o,
  input  word_t imem_instr_i,
  input  logic  redirect_valid_i,
  input  word_t redirect_pc_i,
  output logic  instr_valid_o,
  output word_t instr_o,
  output word_t instr_pc_o,
  input  logic  instr_ready_i,
  output logic  fault_o,
  output word_t fault_pc_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
`endif
);
  localparam word_t LAST_PC = word_t'(IMEM_BYTES - INSTR_BYTES);
  fetch_state_e state_q, state_d;
  word_t next_pc_q, next_pc_d, fault_pc_q, fault_pc_d, pc, ret_pc_q, ret_pc_d;
  logic inflight_q, inflight_d, fault_q, fault_d;
  logic run, redirect, pop, push, want, bad, issue, fault_now;
  logic [2:0] occ;
  logic [1:0] count;
  fetch_entry_t head;
  always_comb begin
    run        = (state_q == RUN) && !rst_i;
    redirect   = run && redirect_valid_i;
    pc         = redirect ? redirect_pc_i : next_pc_q;
    pop        = instr_valid_o && instr_ready_i;
    occ        = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    want       = run && (redirect || occ < 3'd2);
    bad        = pc_bad(pc, LAST_PC);
    issue      = want && !bad;
    fault_now  = want && bad;
    // a redirect kills the return arriving this cycle; its own request lands next cycle
    push       = inflight_q && !redirect && !rst_i;
    state_d    = state_q == BOOT ? RUN : (state_q == RUN && fault_now) ? HALT : state_q;
    next_pc_d  = issue ? pc + word_t'(INSTR_BYTES) : next_pc_q;
    inflight_d = issue;
    ret_pc_d   = issue ? pc : ret_pc_q;
    fault_d    = fault_q || fault_now;
    fault_pc_d = fault_now ? pc : fault_pc_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      next_pc_q  <= RESET_PC;
      inflight_q <= 1'b0;
      ret_pc_q   <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      inflight_q <= inflight_d;
      ret_pc_q   <= ret_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end
  fetch_skid_buf u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .din_i   ('{pc: ret_pc_q, instr: imem_instr_i}),
    .head_o  (head),
    .count_o (count)
  );
  assign imem_pc_o     = rst_i ? RESET_PC : pc;
  assign imem_req_o    = issue;
  assign instr_valid_o = (count != 2'd0) && !rst_i;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetched_q, fetched_d, stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    fetched_d = fetched_q + {31'd0, pop};
    stall_d   = stall_q + {31'd0, run && !issue};
    flush_d   = flush_q + {31'd0, redirect};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end
  assign perf_fetched_o = fetched_q;
  assign perf_stall_o   = stall_q;
  assign perf_flush_o   = flush_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven and hand-sequenced checks of fetch_ctrl.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rdy, rv;
  logic [31:0] rpc, ipc, instr_in, opc, oinstr, fpc;
  logic req, vld, flt;
  logic rst16, rdy16, req16, vld16, flt16;
  logic [31:0] ipc16, instr16, opc16, oinstr16, fpc16;
  int total = 0, pass = 0;
  fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst), .imem_pc_o(ipc), .imem_req_o(req), .imem_instr_i(instr_in),
    .redirect_valid_i(rv), .redirect_pc_i(rpc), .instr_valid_o(vld), .instr_o(oinstr),
    .instr_pc_o(opc), .instr_ready_i(rdy), .fault_o(flt), .fault_pc_o(fpc)
  );
  fetch_ctrl #(.IMEM_BYTES(16)) dut16 (
    .clk_i(clk), .rst_i(rst16), .imem_pc_o(ipc16), .imem_req_o(req16), .imem_instr_i(instr16),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0), .instr_valid_o(vld16), .instr_o(oinstr16),
    .instr_pc_o(opc16), .instr_ready_i(rdy16), .fault_o(flt16), .fault_pc_o(fpc16)
  );
  always_ff @(posedge clk) begin
    instr_in <= 32'hA000_0000 | ipc;
    instr16  <= 32'hA000_0000 | ipc16;
  end
  typedef struct {
    logic rst, rdy, rv;
    logic [31:0] rpc;
    logic req;
    logic [31:0] ipc;
    logic vld;
    logic [31:0] opc;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(logic r, logic y, logic d, logic [31:0] p, logic q,
                             logic [31:0] i, logic l, logic [31:0] o);
    v = '{rst: r, rdy: y, rv: d, rpc: p, req: q, ipc: i, vld: l, opc: o};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] got[$];
    int req_after_fault;
    rst = 1; rdy = 1; rv = 0; rpc = 0;
    rst16 = 1; rdy16 = 1;
    // straight-line run
    tv.push_back(v(1, 1, 0, 0, 0, 32'h00, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 0, 32'h00, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h00, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h04, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h08, 1, 32'h00));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h0C, 1, 32'h04));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h10, 1, 32'h08));
    // backpressure then back-to-back redirects
    tv.push_back(v(1, 0, 0, 0, 0, 32'h00, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 32'h00, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 32'h00, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 32'h04, 0, 0));
    for (int k = 0; k < 5; k++) tv.push_back(v(0, 0, 0, 0, 0, 32'h08, 1, 32'h00));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h08, 1, 32'h00));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h0C, 1, 32'h04));
    tv.push_back(v(0, 0, 1, 32'h40, 1, 32'h40, 1, 32'h08));
    tv.push_back(v(0, 1, 1, 32'h80, 1, 32'h80, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h84, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h88, 1, 32'h80));
    tv.push_back(v(0, 1, 0, 0, 1, 32'h8C, 1, 32'h84));
    cyc();
    cyc();
    foreach (tv[i]) begin
      rst = tv[i].rst; rdy = tv[i].rdy; rv = tv[i].rv; rpc = tv[i].rpc;
      @(negedge clk);
      chk($sformatf("row%0d req", i), {31'd0, req}, {31'd0, tv[i].req});
      chk($sformatf("row%0d imem_pc", i), ipc, tv[i].ipc);
      chk($sformatf("row%0d valid", i), {31'd0, vld}, {31'd0, tv[i].vld});
      chk($sformatf("row%0d fault", i), {31'd0, flt}, 32'd0);
      if (tv[i].vld) begin
        chk($sformatf("row%0d instr_pc", i), opc, tv[i].opc);
        chk($sformatf("row%0d instr", i), oinstr, 32'hA000_0000 | tv[i].opc);
      end
      cyc();
    end
    // misaligned redirect faults, later redirect ignored
    rdy = 0; rv = 1; rpc = 32'h42;
    @(negedge clk);
    chk("misalign req", {31'd0, req}, 32'd0);
    cyc();
    rdy = 1; rv = 1; rpc = 32'h0;
    @(negedge clk);
    chk("misalign fault", {31'd0, flt}, 32'd1);
    chk("misalign fault_pc", fpc, 32'h42);
    chk("halt redirect req", {31'd0, req}, 32'd0);
    chk("halt valid", {31'd0, vld}, 32'd0);
    cyc();
    rv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d req", k), {31'd0, req}, 32'd0);
      chk($sformatf("halt%0d fault", k), {31'd0, flt}, 32'd1);
      cyc();
    end
    // reset mid-run with a full buffer
    rst = 1; rdy = 0;
    cyc();
    rst = 0;
    for (int k = 0; k < 5; k++) cyc();
    @(negedge clk);
    chk("full valid", {31'd0, vld}, 32'd1);
    chk("full req", {31'd0, req}, 32'd0);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rst valid", {31'd0, vld}, 32'd0);
    chk("rst boot req", {31'd0, req}, 32'd0);
    chk("rst fault", {31'd0, flt}, 32'd0);
    chk("rst fault_pc", fpc, 32'd0);
    cyc();
    @(negedge clk);
    chk("restart req", {31'd0, req}, 32'd1);
    chk("restart pc", ipc, 32'h0);
    cyc();
    // range fault on a 16-byte memory
    rst16 = 0;
    req_after_fault = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vld16) begin
        got.push_back(opc16);
        if (oinstr16 !== (32'hA000_0000 | opc16)) chk("range instr", oinstr16, 32'hA000_0000 | opc16);
      end
      if (flt16 && req16) req_after_fault++;
      cyc();
    end
    chk("range count", got.size(), 32'd4);
    foreach (got[i]) chk($sformatf("range pc%0d", i), got[i], 32'(i * 4));
    chk("range fault", {31'd0, flt16}, 32'd1);
    chk("range fault_pc", fpc16, 32'h10);
    chk("range req after fault", req_after_fault, 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
